// File: rtl/bfmac_pkg.sv
// Shared encodings for the bit-fusion MAC job sequencer: job modes, shift
// codes, fused-8x8 shift words and the sequencer state enum.
package bfmac_pkg;

  typedef enum logic [1:0] {
    MODE_FUSED8 = 2'd0,
    MODE_RAW    = 2'd1,
    MODE_USER   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Per-block shift codes packed into the sft0/sft1 words.
  typedef enum logic [1:0] {
    SFT_NONE = 2'b00,
    SFT_SH2  = 2'b01,
    SFT_SH4  = 2'b10,
    SFT_SH8  = 2'b11
  } sft_code_e;

  localparam logic [19:0] SFT0_FUSED8 = 20'h86666;
  localparam logic [19:0] SFT1_FUSED8 = 20'hE8888;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic [19:0] sft_fill(input logic [1:0] code);
    return {10{code}};
  endfunction

endpackage

// File: rtl/bfmac_sft_sel.sv
// Maps the latched job mode and user words onto the tile's sft0/sft1 pair.
module bfmac_sft_sel
  import bfmac_pkg::*;
(
  input  mode_e       mode,
  input  logic [19:0] cfg_sft0,
  input  logic [19:0] cfg_sft1,
  output logic [19:0] sft0,
  output logic [19:0] sft1
);

  // Reserved mode falls back to the all-zero (RAW) shift pattern.
  always_comb begin
    sft0 = sft_fill(SFT_NONE);
    sft1 = sft_fill(SFT_NONE);
    case (mode)
      MODE_FUSED8: begin
        sft0 = SFT0_FUSED8;
        sft1 = SFT1_FUSED8;
      end
      MODE_USER: begin
        sft0 = cfg_sft0;
        sft1 = cfg_sft1;
      end
      MODE_RAW: begin
        sft0 = sft_fill(SFT_NONE);
        sft1 = sft_fill(SFT_NONE);
      end
      default: begin
        sft0 = sft_fill(SFT_NONE);
        sft1 = sft_fill(SFT_NONE);
      end
    endcase
  end

endmodule

// File: rtl/bfmac_seq_ctrl.sv
// Job sequencer for one bit-fusion MAC tile: streams K operand pairs, drains the
// accumulator pipeline and returns the accumulator delta as the job result.
module bfmac_seq_ctrl
  import bfmac_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [CNT_W-1:0] job_len,
  input  logic [1:0]       job_mode,
  input  logic [19:0]      cfg_sft0,
  input  logic [19:0]      cfg_sft1,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [7:0]       mac_in1,
  output logic [7:0]       mac_in2,
  output logic [19:0]      mac_sft0,
  output logic [19:0]      mac_sft1,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_abort
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] cnt_r;
  mode_e            mode_r;
  logic [19:0]      usr_sft0_r;
  logic [19:0]      usr_sft1_r;
  logic [19:0]      sel_sft0_s;
  logic [19:0]      sel_sft1_s;
  logic [ACC_W-1:0] base_r;
  logic             abort_r;
  logic             accept_s;

  bfmac_sft_sel u_sft_sel (
    .mode     (mode_r),
    .cfg_sft0 (usr_sft0_r),
    .cfg_sft1 (usr_sft1_r),
    .sft0     (sel_sft0_s),
    .sft1     (sel_sft1_s)
  );

  assign accept_s = op_valid & op_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode; abort wins over a presented operand.
  always_comb begin
    state_nxt_s = state_r;
    job_ready   = 1'b0;
    op_ready    = 1'b0;
    case (state_r)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_nxt_s = S_START;
        else           state_nxt_s = S_IDLE;
      end
      S_START: begin
        if (len_r == {CNT_W{1'b0}}) state_nxt_s = S_DRAIN1;
        else                        state_nxt_s = S_RUN;
      end
      S_RUN: begin
        op_ready = ~abort;
        if (abort)
          state_nxt_s = S_DRAIN1;
        else if (op_valid && ((cnt_r + CNT_W'(1)) == len_r))
          state_nxt_s = S_DRAIN1;
        else
          state_nxt_s = S_RUN;
      end
      S_DRAIN1: state_nxt_s = S_DRAIN2;
      S_DRAIN2: state_nxt_s = S_DONE;
      S_DONE: begin
        if (res_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Job latch, operand pipeline, base snapshot and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r      <= {CNT_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      mode_r     <= MODE_FUSED8;
      usr_sft0_r <= 20'h00000;
      usr_sft1_r <= 20'h00000;
      base_r     <= {ACC_W{1'b0}};
      abort_r    <= 1'b0;
      mac_in1    <= 8'h00;
      mac_in2    <= 8'h00;
      mac_sft0   <= 20'h00000;
      mac_sft1   <= 20'h00000;
      res_valid  <= 1'b0;
      res_data   <= {ACC_W{1'b0}};
      res_abort  <= 1'b0;
    end else begin
      if (accept_s) begin
        mac_in1 <= op_a;
        mac_in2 <= op_b;
      end else begin
        mac_in1 <= 8'h00;
        mac_in2 <= 8'h00;
      end
      case (state_r)
        S_IDLE: begin
          if (job_valid) begin
            len_r   <= job_len;
            mode_r  <= mode_e'(job_mode);
            abort_r <= 1'b0;
            if (mode_e'(job_mode) == MODE_USER) begin
              usr_sft0_r <= cfg_sft0;
              usr_sft1_r <= cfg_sft1;
            end
          end
        end
        S_START: begin
          mac_sft0 <= sel_sft0_s;
          mac_sft1 <= sel_sft1_s;
          base_r   <= mac_acc;
          cnt_r    <= {CNT_W{1'b0}};
        end
        S_RUN: begin
          if (accept_s) cnt_r <= cnt_r + CNT_W'(1);
          if (abort)    abort_r <= 1'b1;
        end
        S_DRAIN2: begin
          res_data  <= mac_acc - base_r;
          res_abort <= abort_r;
          res_valid <= 1'b1;
        end
        S_DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfmac_seq_ctrl.sv
// Directed bench for bfmac_seq_ctrl with a behavioural tile accumulator model.
module tb_bfmac_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_len;
  logic [1:0]  job_mode;
  logic [19:0] cfg_sft0;
  logic [19:0] cfg_sft1;
  logic        abort;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  mac_in1;
  logic [7:0]  mac_in2;
  logic [19:0] mac_sft0;
  logic [19:0] mac_sft1;
  logic [19:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic        res_abort;

  int n_cmp = 0;
  int n_err = 0;
  int opr_cnt = 0;
  int opr_snap;

  // Tile model: never cleared, starts near wrap so the base subtraction matters.
  logic [19:0] tile_acc = 20'hFFFF0;
  assign mac_acc = tile_acc;
  always @(posedge clk) tile_acc <= tile_acc + 20'(mac_in1) * 20'(mac_in2);

  always @(negedge clk) if (op_ready) opr_cnt++;

  bfmac_seq_ctrl #(.ACC_W(20), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_mode(job_mode), .cfg_sft0(cfg_sft0), .cfg_sft1(cfg_sft1),
    .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_sft0(mac_sft0), .mac_sft1(mac_sft1),
    .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_abort(res_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] len, input logic [1:0] mode,
                           input logic [19:0] s0, input logic [19:0] s1);
    int n;
    job_len = len; job_mode = mode; cfg_sft0 = s0; cfg_sft1 = s1;
    job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("job_ready", 32'(job_ready), 32'd1);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int gap);
    int n;
    op_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      check("bubble_in1", 32'(mac_in1), 32'd0);
    end
    op_a = a; op_b = b; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("op_ready", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    check("mac_in1", 32'(mac_in1), 32'(a));
    check("mac_in2", 32'(mac_in2), 32'(b));
    op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
  endtask

  // exp_lat counts clock edges from the last accepting edge to res_valid.
  task automatic wait_res(input string tag, input int exp_lat,
                          input logic [19:0] exp_data, input logic exp_abort);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check({tag, "_abort"}, 32'(res_abort), 32'(exp_abort));
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_vclr"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"}, 32'(job_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_len = 16'd0; job_mode = 2'd0;
    cfg_sft0 = 20'h0; cfg_sft1 = 20'h0; abort = 1'b0; op_valid = 1'b0;
    op_a = 8'h00; op_b = 8'h00; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_job_ready", 32'(job_ready), 32'd1);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_in1", 32'(mac_in1), 32'd0);
    check("rst_sft0", 32'(mac_sft0), 32'd0);
    check("rst_sft1", 32'(mac_sft1), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // FUSED8, K=3, no stalls: 15+14+100.
    start_job(16'd3, 2'd0, 20'h0, 20'h0);
    send_op(8'd3, 8'd5, 0);
    send_op(8'd2, 8'd7, 0);
    send_op(8'd10, 8'd10, 0);
    wait_res("fused", 2, 20'd129, 1'b0);
    check("fused_sft0", 32'(mac_sft0), 32'h86666);
    check("fused_sft1", 32'(mac_sft1), 32'hE8888);
    consume("fused");

    // Same job with bubbles, then a one-pair job.
    start_job(16'd3, 2'd0, 20'h0, 20'h0);
    send_op(8'd3, 8'd5, 0);
    send_op(8'd2, 8'd7, 2);
    send_op(8'd10, 8'd10, 2);
    wait_res("stall", 2, 20'd129, 1'b0);
    consume("stall");
    start_job(16'd1, 2'd0, 20'h0, 20'h0);
    send_op(8'd1, 8'd1, 0);
    wait_res("second", 2, 20'd1, 1'b0);
    consume("second");

    // K=0 in RAW mode.
    opr_snap = opr_cnt;
    start_job(16'd0, 2'd1, 20'h0, 20'h0);
    wait_res("k0", 3, 20'd0, 1'b0);
    check("k0_no_op_ready", 32'(opr_cnt - opr_snap), 32'd0);
    check("raw_sft0", 32'(mac_sft0), 32'd0);
    check("raw_sft1", 32'(mac_sft1), 32'd0);
    consume("k0");

    // USER mode: 63 + 65025.
    start_job(16'd2, 2'd2, 20'h12345, 20'hABCDE);
    send_op(8'd7, 8'd9, 0);
    send_op(8'd255, 8'd255, 0);
    wait_res("user", 2, 20'd65088, 1'b0);
    check("user_sft0", 32'(mac_sft0), 32'h12345);
    check("user_sft1", 32'(mac_sft1), 32'hABCDE);
    consume("user");

    // Reserved mode behaves as RAW.
    start_job(16'd1, 2'd3, 20'hFFFFF, 20'hFFFFF);
    send_op(8'd2, 8'd3, 0);
    wait_res("rsvd", 2, 20'd6, 1'b0);
    check("rsvd_sft0", 32'(mac_sft0), 32'd0);
    check("rsvd_sft1", 32'(mac_sft1), 32'd0);
    consume("rsvd");

    // Abort after 2 of 5 pairs; the pair shown with abort is refused.
    start_job(16'd5, 2'd0, 20'h0, 20'h0);
    send_op(8'd4, 8'd4, 0);
    send_op(8'd5, 8'd5, 0);
    op_a = 8'd6; op_b = 8'd6; op_valid = 1'b1; abort = 1'b1;
    #1;
    check("abort_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
    check("abort_in1", 32'(mac_in1), 32'd0);
    wait_res("abort", 2, 20'd41, 1'b1);
    consume("abort");

    // Result held while the consumer stalls.
    res_ready = 1'b0;
    start_job(16'd1, 2'd0, 20'h0, 20'h0);
    send_op(8'd3, 8'd3, 0);
    wait_res("hold", 2, 20'd9, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'd9);
      check("hold_abort", 32'(res_abort), 32'd0);
      check("hold_job_ready", 32'(job_ready), 32'd0);
      check("hold_op_ready", 32'(op_ready), 32'd0);
      check("hold_in1", 32'(mac_in1), 32'd0);
      check("hold_in2", 32'(mac_in2), 32'd0);
    end
    consume("hold");

    // Reset in the middle of RUN, then a clean job.
    start_job(16'd4, 2'd2, 20'h5A5A5, 20'h3C3C3);
    send_op(8'd8, 8'd8, 0);
    check("pre_rst_sft0", 32'(mac_sft0), 32'h5A5A5);
    rst = 1'b1;
    #1;
    check("midrst_in1", 32'(mac_in1), 32'd0);
    check("midrst_sft0", 32'(mac_sft0), 32'd0);
    check("midrst_sft1", 32'(mac_sft1), 32'd0);
    check("midrst_op_ready", 32'(op_ready), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_job_ready", 32'(job_ready), 32'd1);
    start_job(16'd2, 2'd0, 20'h0, 20'h0);
    send_op(8'd1, 8'd2, 0);
    send_op(8'd3, 8'd4, 0);
    wait_res("postrst", 2, 20'd14, 1'b0);
    consume("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
